m_dmem_loader: RTL
==================

# m_dmem_loader

Upstream initialiser for the cached data memory: it accepts a raw byte stream from a UART receiver and buffers it in a small show-ahead FIFO. It packs the bytes little-endian into 32-bit words and writes them through the memory's init port (init wen/addr/data), one word at a time, obeying the memory's stall signal. After WORDS words have been accepted by the memory it raises the init-done flag, which hands the data-memory port over to the CPU.

## Interface
- WORDS, 4096: number of 32-bit words to load; 0 allowed.
- BASE_ADDR, 32'h0: byte address of the first word; must be 4-byte aligned.
- FIFO_AW, 4: byte FIFO depth is 2**FIFO_AW.
- i_clk  in  1  sole clock. One clock; reset is asynchronous and active-high.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe per byte; no backpressure.
- i_stall  in  1  data-memory stall (o_dmem_stall of the cached memory).
- o_init_wen  out  4  4'hF for exactly one cycle per word write, else 0.
- o_init_addr  out  32  write byte address.
- o_init_data  out  32  write data.
- o_init_done  out  1  sticky high once all words are committed.
- o_overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- o_word_count  out  32  words issued so far.

## Operation
- Reset values (asserted asynchronously): o_init_wen=0, o_init_addr=BASE_ADDR, o_init_data=0, o_init_done=0, o_overflow=0, o_word_count=0. FIFO is emptied, state=S_FILL, byte index=0.
- Reset asserted mid-word or mid-write abandons the operation. No output glitches are produced beyond the asynchronous clear.
- All outputs are registered. There is no combinational path from i_stall to any output.
- FIFO push: when i_rx_valid && !full && !o_init_done. When i_rx_valid && full: byte dropped, o_overflow<=1. Bytes arriving after done are dropped silently and do not set o_overflow.
- Simultaneous push and pop on a full FIFO: the pop frees a slot only next cycle, so the byte is dropped. The full flag is evaluated before the pop.
- FSM states:
  - S_FILL: pops one byte per cycle while the FIFO is non-empty. Byte k goes to data[8k+7:8k], k=0..3. After the 4th pop → S_WAIT.
  - S_WAIT: o_init_wen=0. On an edge where i_stall==0 → S_ISSUE (o_init_wen<=4'hF).
  - S_ISSUE: lasts exactly one cycle, with o_init_wen=4'hF and addr/data stable. Next edge: o_init_wen<=0, o_word_count+=1, o_init_addr+=4 (32-bit wrap). Then:
    - if count+1==WORDS → S_FLUSH;
    - else → S_FILL.
  - S_FLUSH: waits until i_stall==0 is sampled → S_DONE, o_init_done<=1.
  - S_DONE: terminal until reset. o_init_wen stays 0.
- o_init_addr and o_init_data are updated only while o_init_wen=0, so they are stable across each write.
- When WORDS==0: go straight to S_DONE. o_init_done=1 on the first edge after reset release.
- The memory's write-through path latches the request in the same cycle it is presented. wen therefore must never be held for two cycles, and must be preceded by a stall-free cycle with wen=0; S_WAIT guarantees both.

## Timing
- Byte pushed at edge T is poppable at edge T+1 at the earliest (show-ahead head).
- Minimum per word: 4 cycles in S_FILL, 1 in S_WAIT, 1 in S_ISSUE, giving 6 cycles/word when bytes are pre-buffered and i_stall=0.
- Write issue latency: o_init_wen rises on the edge after the first S_WAIT cycle with i_stall=0.
- Done latency: the last S_ISSUE ends at edge E. o_init_done rises at edge E+1+n, where n = number of consecutive cycles after E with i_stall=1.
- Behaviour with i_stall=1 depends on state:
  - in S_WAIT and S_FLUSH: the FSM holds;
  - in S_FILL: has no effect;
  - in S_ISSUE: is ignored (the write is already presented).

## Test plan
- Reset, WORDS=2, BASE_ADDR=0x100, bytes 11 22 33 44 55 66 77 88 back-to-back, i_stall=0 → two one-cycle wen=F pulses: (0x100, 0x44332211) then (0x104, 0x88776655). Done rises one cycle after the second pulse ends; count=2.
- Same stream with i_stall=1 for 10 cycles starting in S_WAIT of word 0 → wen stays 0 during the stall and pulses once on the edge after stall drops. Data and address are unchanged.
- FIFO_AW=2 and 6 bytes pushed while held in S_WAIT under stall → o_overflow=1. Bytes 5 and 6 are dropped, and word 1 is formed from the next bytes after the FIFO has space.
- WORDS=0 → o_init_done=1 one edge after reset release. wen is never asserted.
- Stall asserted for 3 cycles right after the final issue → done delayed exactly 3 cycles. Extra bytes sent after done do not set o_overflow or change count.
- Assert i_rst mid-word (after 2 bytes) → all outputs return to their reset values immediately. A fresh 4-byte stream then yields word 0 at BASE_ADDR.

Source files
------------

// File: rtl/m_dmem_loader.sv
// Data-memory initialiser: buffers UART bytes in a show-ahead FIFO, packs them
// little-endian into 32-bit words and writes them through the memory init port.
module m_dmem_loader #(
    parameter int          WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          FIFO_AW   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_stall,
    output logic [3:0]  o_init_wen,
    output logic [31:0] o_init_addr,
    output logic [31:0] o_init_data,
    output logic        o_init_done,
    output logic        o_overflow,
    output logic [31:0] o_word_count
);

    localparam int          DEPTH    = 2 ** FIFO_AW;
    localparam logic [31:0] WORDS_W  = 32'(WORDS);
    localparam bit          NO_WORDS = (WORDS == 0);

    typedef enum logic [2:0] {
        S_FILL,
        S_WAIT,
        S_ISSUE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          count_q, count_d;
    logic [3:0]           wen_q, wen_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_q, rd_q;
    logic [FIFO_AW:0]     cnt_q;
    logic                 full, empty, push, pop;
    logic [7:0]           head;

    // Full is taken before any pop this cycle, so a freed slot is usable only next cycle.
    assign full  = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = i_rx_valid && !full && !done_q;
    assign head  = mem_q[rd_q];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_q] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        count_d = count_q;
        wen_d   = 4'h0;
        done_d  = done_q;
        ovf_d   = ovf_q | (i_rx_valid && full && !done_q);
        pop     = 1'b0;
        case (state_q)
            S_FILL: begin
                if (NO_WORDS) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (!empty) begin
                    pop                         = 1'b1;
                    data_d[{idx_q, 3'b000} +: 8] = head;
                    idx_d                       = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WAIT;
                    end
                end
            end
            // A stall-free idle cycle always precedes the one-cycle write strobe.
            S_WAIT: begin
                if (!i_stall) begin
                    state_d = S_ISSUE;
                    wen_d   = 4'hF;
                end
            end
            S_ISSUE: begin
                count_d = count_q + 32'd1;
                addr_d  = addr_q + 32'd4;
                if (count_q + 32'd1 == WORDS_W) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FLUSH: begin
                if (!i_stall) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_FILL;
            idx_q   <= 2'd0;
            data_q  <= 32'h0;
            addr_q  <= BASE_ADDR;
            count_q <= 32'h0;
            wen_q   <= 4'h0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_init_wen   = wen_q;
    assign o_init_addr  = addr_q;
    assign o_init_data  = data_q;
    assign o_init_done  = done_q;
    assign o_overflow   = ovf_q;
    assign o_word_count = count_q;

endmodule
